ir_fetch_sequencer: RTL and testbench
=====================================

IR_FETCH_SEQUENCER -- requirements
Module: ir_fetch_sequencer

Interface
REQ-001 Parameter WAIT_LIMIT, default 15: consecutive not-ready cycles in a fetch state before a fetch error is raised.
REQ-002 Parameter CNT_W, default 8: width of the completed-instruction counter.
REQ-003 Clock  input  1  the single system clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset; when low, all state and outputs take their reset values immediately.
REQ-005 Start  input  1  level; fetching is enabled while high.
REQ-006 Halt  input  1  level; stops fetching after the current instruction completes.
REQ-007 Flush  input  1  aborts any in-progress fetch and clears an error.
REQ-008 MemReady  input  1  memory presents a valid instruction byte on the IR data input this cycle.
REQ-009 DecodeAck  input  1  the decoder has consumed the current instruction.
REQ-010 MemRead  output  1  byte fetch request to memory.
REQ-011 IR_Write  output  1  drives the instruction register Write input.
REQ-012 IR_LH  output  1  drives the instruction register LH input (0 = LSB, 1 = MSB).
REQ-013 PC_Inc  output  1  one-cycle program counter increment per accepted byte.
REQ-014 InstrValid  output  1  the instruction register holds a complete 16-bit instruction.
REQ-015 FetchErr  output  1  the memory wait limit was exceeded.
REQ-016 FetchCount  output  CNT_W  number of completed instruction fetches, modulo 2^CNT_W.
REQ-017 FsmState  output  3  encoded current state, for debug.

Function
REQ-018 The block SHALL implement the states IDLE=0, FETCH_L=1, FETCH_H=2, VALID=3 and ERROR=4, encoded on FsmState.
REQ-019 IDLE: if Start=1 and Halt=0, the next state SHALL be FETCH_L; otherwise the block SHALL remain in IDLE.
REQ-020 FETCH_L: MemRead=1 and IR_LH=0; on MemReady=1 the next state SHALL be FETCH_H.
REQ-021 FETCH_H: MemRead=1 and IR_LH=1; on MemReady=1 the next state SHALL be VALID, and FetchCount SHALL increment on that same edge.
REQ-022 IR_Write and PC_Inc SHALL be combinational and equal to MemRead AND MemReady AND NOT Flush, so the IR captures the byte on the same edge the byte is accepted.
REQ-023 IR_LH SHALL be 0 in every state other than FETCH_H.
REQ-024 VALID: InstrValid=1 and MemRead=0; on DecodeAck=1 the next state SHALL be FETCH_L if Start=1 and Halt=0, otherwise IDLE; DecodeAck SHALL be ignored in all other states.
REQ-025 Halt SHALL NOT interrupt FETCH_L or FETCH_H; a started instruction always completes through to VALID.
REQ-026 The wait counter SHALL count consecutive fetch-state cycles with MemReady=0, SHALL clear on MemReady=1 and on every state change, and on reaching WAIT_LIMIT the next state SHALL be ERROR.
REQ-027 ERROR: FetchErr=1, MemRead=0, IR_Write=0; the block SHALL exit ERROR only via Flush or Reset.
REQ-028 Flush=1 in any state SHALL force the next state to IDLE, clear the wait counter and suppress IR_Write and PC_Inc that cycle; Flush has priority over all other inputs; FetchCount is not modified.
REQ-029 FetchCount SHALL wrap from 2^CNT_W-1 to 0 without error.
REQ-030 Outputs not asserted by a state SHALL be 0 in that state.

Reset
REQ-031 While Reset=0: state=IDLE, wait counter=0, FetchCount=0; MemRead, IR_Write, IR_LH, PC_Inc, InstrValid and FetchErr all 0; FsmState=0.
REQ-032 Reset asserted mid-fetch SHALL abandon the fetch immediately; no IR_Write or PC_Inc pulse is produced after Reset falls.
REQ-033 After Reset rises, the first transition out of IDLE SHALL occur on the first rising edge with Start=1 and Halt=0.

Verification
REQ-034 Start=1, MemReady=1 continuously, DecodeAck=1 in VALID -> repeating 3-cycle pattern FETCH_L/FETCH_H/VALID; IR_Write=1 with IR_LH=0 then 1; two PC_Inc pulses per instruction; FetchCount=3 after 3 instructions.
REQ-035 MemReady=0 for 4 cycles in FETCH_L, then 1 -> MemRead held for 5 cycles, exactly one IR_Write and one PC_Inc, state FETCH_H, FetchErr=0.
REQ-036 WAIT_LIMIT=15 and MemReady=0 held in FETCH_H -> ERROR entered after 15 wait cycles, FetchErr=1; Flush=1 for 1 cycle -> IDLE, FetchErr=0.
REQ-037 Halt=1 raised during FETCH_L -> FETCH_H and VALID still complete; after DecodeAck=1 -> IDLE, MemRead=0.
REQ-038 Flush=1 in the same cycle as MemReady=1 in FETCH_H -> IR_Write=0, PC_Inc=0, next state IDLE, FetchCount unchanged.
REQ-039 CNT_W=2, 5 completed fetches -> FetchCount sequence 1,2,3,0,1; Reset=0 asserted mid-FETCH_H -> all outputs 0 immediately.

Source files
------------

// File: rtl/ir_fetch_sequencer.sv
// Instruction fetch sequencer: pulls a 16-bit instruction as two bytes (LSB, then MSB)
// into the instruction register, with a memory wait watchdog and a completed-fetch counter.
module ir_fetch_sequencer #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    input  logic             Flush,
    input  logic             MemReady,
    input  logic             DecodeAck,
    output logic             MemRead,
    output logic             IR_Write,
    output logic             IR_LH,
    output logic             PC_Inc,
    output logic             InstrValid,
    output logic             FetchErr,
    output logic [CNT_W-1:0] FetchCount,
    output logic [2:0]       FsmState
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_L = 3'd1,
        FETCH_H = 3'd2,
        VALID   = 3'd3,
        ERROR   = 3'd4
    } state_t;

    localparam int WAIT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    state_t             state_reg, state_next;
    logic [WAIT_W-1:0]  wait_reg, wait_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               mem_read_reg, ir_lh_reg, instr_valid_reg, fetch_err_reg;
    logic               byte_accept;

    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        count_next = count_reg;
        if (Flush) begin
            state_next = IDLE;
            wait_next  = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (Start && !Halt)
                        state_next = FETCH_L;
                end
                FETCH_L, FETCH_H: begin
                    // Halt is deliberately not looked at here: a started instruction always completes.
                    if (MemReady) begin
                        wait_next = '0;
                        if (state_reg == FETCH_L) begin
                            state_next = FETCH_H;
                        end else begin
                            state_next = VALID;
                            count_next = count_reg + CNT_W'(1);
                        end
                    end else if (wait_reg == WAIT_LAST) begin
                        state_next = ERROR;
                        wait_next  = '0;
                    end else begin
                        wait_next = wait_reg + WAIT_W'(1);
                    end
                end
                VALID: begin
                    if (DecodeAck)
                        state_next = (Start && !Halt) ? FETCH_L : IDLE;
                end
                ERROR: begin
                    state_next = ERROR;
                end
                default: begin
                    state_next = IDLE;
                    wait_next  = '0;
                end
            endcase
        end
    end

    // Per-state outputs are registered from the next state so they change with the state itself.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg       <= IDLE;
            wait_reg        <= '0;
            count_reg       <= '0;
            mem_read_reg    <= 1'b0;
            ir_lh_reg       <= 1'b0;
            instr_valid_reg <= 1'b0;
            fetch_err_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wait_reg        <= wait_next;
            count_reg       <= count_next;
            mem_read_reg    <= (state_next == FETCH_L) || (state_next == FETCH_H);
            ir_lh_reg       <= (state_next == FETCH_H);
            instr_valid_reg <= (state_next == VALID);
            fetch_err_reg   <= (state_next == ERROR);
        end
    end

    // The IR must latch the byte on the very edge it is accepted, so this path stays combinational.
    assign byte_accept = mem_read_reg && MemReady && !Flush;

    assign MemRead    = mem_read_reg;
    assign IR_Write   = byte_accept;
    assign PC_Inc     = byte_accept;
    assign IR_LH      = ir_lh_reg;
    assign InstrValid = instr_valid_reg;
    assign FetchErr   = fetch_err_reg;
    assign FetchCount = count_reg;
    assign FsmState   = state_reg;

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
// Directed bench for ir_fetch_sequencer: vector table for the main flow plus hand-written
// sequences for the wait watchdog, error recovery and asynchronous reset.
module tb_ir_fetch_sequencer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0, Halt = 1'b0, Flush = 1'b0, MemReady = 1'b0, DecodeAck = 1'b0;
    logic       MemRead, IR_Write, IR_LH, PC_Inc, InstrValid, FetchErr;
    logic [7:0] FetchCount;
    logic [2:0] FsmState;
    logic       mem_read2, ir_write2, ir_lh2, pc_inc2, instr_valid2, fetch_err2;
    logic [1:0] fetch_count2;
    logic [2:0] fsm_state2;

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    ir_fetch_sequencer #(.WAIT_LIMIT(15), .CNT_W(8)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Halt(Halt), .Flush(Flush),
        .MemReady(MemReady), .DecodeAck(DecodeAck), .MemRead(MemRead), .IR_Write(IR_Write),
        .IR_LH(IR_LH), .PC_Inc(PC_Inc), .InstrValid(InstrValid), .FetchErr(FetchErr),
        .FetchCount(FetchCount), .FsmState(FsmState)
    );

    // Narrow-counter instance shares the stimulus; used for the wrap-around behaviour.
    ir_fetch_sequencer #(.WAIT_LIMIT(15), .CNT_W(2)) dut2 (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Halt(Halt), .Flush(Flush),
        .MemReady(MemReady), .DecodeAck(DecodeAck), .MemRead(mem_read2), .IR_Write(ir_write2),
        .IR_LH(ir_lh2), .PC_Inc(pc_inc2), .InstrValid(instr_valid2), .FetchErr(fetch_err2),
        .FetchCount(fetch_count2), .FsmState(fsm_state2)
    );

    typedef struct {
        logic       s, h, f, r, a;   // Start, Halt, Flush, MemReady, DecodeAck
        logic [2:0] st;              // expected state before the edge
        logic       iw;              // expected IR_Write / PC_Inc
        logic [7:0] cnt;             // expected FetchCount before the edge
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic s, logic h, logic f, logic r, logic a,
                                logic [2:0] st, logic iw, logic [7:0] cnt);
        vec_t v;
        v.s = s; v.h = h; v.f = f; v.r = r; v.a = a;
        v.st = st; v.iw = iw; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input vec_t v, input string name);
        logic [16:0] act, exp;
        logic        mr, lh, iv, fe;
        mr  = (v.st == 3'd1) || (v.st == 3'd2);
        lh  = (v.st == 3'd2);
        iv  = (v.st == 3'd3);
        fe  = (v.st == 3'd4);
        act = {FsmState, MemRead, IR_Write, IR_LH, PC_Inc, InstrValid, FetchErr, FetchCount};
        exp = {v.st, mr, v.iw, lh, v.iw, iv, fe, v.cnt};
        checks++;
        if (act !== exp || fetch_count2 !== v.cnt[1:0] || fsm_state2 !== v.st || ir_write2 !== v.iw) begin
            errors++;
            $display("FAIL %s: got st/mr/iw/lh/pi/iv/fe/cnt=%h cnt2=%0d, want %h cnt2=%0d",
                     name, act, fetch_count2, exp, v.cnt[1:0]);
        end else begin
            $display("ok   %s: st=%0d iw=%0b cnt=%0d cnt2=%0d", name, FsmState, IR_Write, FetchCount, fetch_count2);
        end
    endtask

    // Drive one cycle's inputs mid-cycle and check pre-edge outputs; the next rising edge applies them.
    task automatic run(input vec_t v, input string name);
        @(negedge Clock);
        Start = v.s; Halt = v.h; Flush = v.f; MemReady = v.r; DecodeAck = v.a;
        #1;
        check(v, name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Main flow: back-to-back fetches, stalls, halt mid-fetch, flush on the accepting cycle.
        vecs.push_back(mk(0,0,0,0,0, 0,0,0));
        vecs.push_back(mk(1,1,0,0,0, 0,0,0));   // Halt blocks the start
        vecs.push_back(mk(1,0,0,1,0, 0,0,0));   // MemReady in IDLE is not a write
        vecs.push_back(mk(1,0,0,1,0, 1,1,0));
        vecs.push_back(mk(1,0,0,1,0, 2,1,0));
        vecs.push_back(mk(1,0,0,1,1, 3,0,1));
        vecs.push_back(mk(1,0,0,1,0, 1,1,1));
        vecs.push_back(mk(1,0,0,1,0, 2,1,1));
        vecs.push_back(mk(1,0,0,1,1, 3,0,2));
        vecs.push_back(mk(1,0,0,1,0, 1,1,2));
        vecs.push_back(mk(1,0,0,1,0, 2,1,2));
        vecs.push_back(mk(1,0,0,1,0, 3,0,3));   // no DecodeAck: hold VALID
        vecs.push_back(mk(1,0,0,1,1, 3,0,3));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1,0,0,0,1, 1,0,3)); // stall, DecodeAck ignored
        vecs.push_back(mk(1,1,0,1,0, 1,1,3));   // Halt raised in FETCH_L
        vecs.push_back(mk(1,1,0,0,0, 2,0,3));
        vecs.push_back(mk(1,1,0,1,0, 2,1,3));
        vecs.push_back(mk(1,1,0,0,1, 3,0,4));   // ack with Halt -> IDLE
        vecs.push_back(mk(1,1,0,0,0, 0,0,4));
        vecs.push_back(mk(1,0,0,0,0, 0,0,4));
        vecs.push_back(mk(1,0,0,1,0, 1,1,4));
        vecs.push_back(mk(1,0,1,1,0, 2,0,4));   // Flush with MemReady in FETCH_H
        vecs.push_back(mk(0,0,0,0,0, 0,0,4));
        vecs.push_back(mk(1,0,0,0,0, 0,0,4));
        vecs.push_back(mk(1,0,0,1,0, 1,1,4));
        vecs.push_back(mk(1,0,0,1,0, 2,1,4));
        vecs.push_back(mk(0,0,0,1,0, 3,0,5));
        vecs.push_back(mk(0,0,0,1,1, 3,0,5));
        vecs.push_back(mk(0,0,0,0,0, 0,0,5));

        #2;
        check(mk(0,0,0,0,0, 0,0,0), "reset_state");
        @(negedge Clock);
        Reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            run(vecs[i], $sformatf("vec%0d", i));

        // Watchdog boundary: 14 stalls survive, the 15th stall cycle enters ERROR.
        run(mk(1,0,0,0,0, 0,0,5), "wd_start");
        for (int i = 0; i < 14; i++)
            run(mk(1,0,0,0,0, 1,0,5), $sformatf("wd_l_stall%0d", i));
        run(mk(1,0,0,1,0, 1,1,5), "wd_l_accept");
        for (int i = 0; i < 15; i++)
            run(mk(1,0,0,0,0, 2,0,5), $sformatf("wd_h_stall%0d", i));
        run(mk(1,0,0,1,1, 4,0,5), "err_hold0");
        run(mk(1,0,0,1,1, 4,0,5), "err_hold1");
        run(mk(1,0,1,1,0, 4,0,5), "err_flush");
        run(mk(0,0,0,0,0, 0,0,5), "err_cleared");

        // Asynchronous reset during FETCH_H with a byte being accepted.
        run(mk(1,0,0,0,0, 0,0,5), "rst_go");
        run(mk(1,0,0,1,0, 1,1,5), "rst_l");
        run(mk(1,0,0,1,0, 2,1,5), "rst_h_pre");
        Reset = 1'b0;
        #1;
        check(mk(1,0,0,1,0, 0,0,0), "rst_async");
        @(posedge Clock);
        #1;
        check(mk(1,0,0,1,0, 0,0,0), "rst_held");
        @(negedge Clock);
        Reset = 1'b1;
        MemReady = 1'b0;
        run(mk(1,0,0,0,0, 1,0,0), "rst_first_edge");
        run(mk(1,0,0,1,0, 1,1,0), "rst_resume");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
